// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: splits each wide beat into its kept lanes,
// emitted lowest lane first, with packet-end marked on the last kept lane.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int IDX_W = $clog2(T_DATA_RATIO);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                  state_q, state_d;
    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem_q, rem_d;
    logic                    last_q, last_d;
    logic [T_DATA_RATIO-1:0] low_mask;
    logic [IDX_W-1:0]        k;
    logic                    one_left;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    load;

    // Descending scan so the lowest remaining lane wins.
    always_comb begin
        k        = '0;
        low_mask = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                k           = IDX_W'(i);
                low_mask    = '0;
                low_mask[i] = 1'b1;
            end
        end
    end

    assign one_left  = ($countones(rem_q) == 1);
    assign m_valid_o = (state_q == SEND);
    assign m_data_o  = m_valid_o ? data_q[k] : '0;
    assign m_last_o  = m_valid_o && one_left && last_q;
    assign s_ready_o = (state_q == IDLE) || (one_left && m_ready_i);

    assign in_xfer  = s_valid_i && s_ready_o;
    assign out_xfer = m_valid_o && m_ready_i;
    assign load     = in_xfer && (|s_keep_i);

    // A load overrides the final-lane retire so back-to-back beats stream without a bubble.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        last_d  = last_q;
        if (out_xfer) begin
            rem_d = rem_q & ~low_mask;
            if (one_left) begin
                state_d = IDLE;
            end
        end
        if (load) begin
            data_d  = s_data_i;
            rem_d   = s_keep_i;
            last_d  = s_last_i;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: doc/stream_downsize.md
STREAM_DOWNSIZE -- requirements
Module: stream_downsize

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 4: bit width of one narrow lane.
REQ-002 SHALL have parameter T_DATA_RATIO, default 2: number of lanes per wide input beat, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port s_data_i, input, T_DATA_WIDTH x T_DATA_RATIO unpacked array, wide beat; index 0 is lane 0.
REQ-006 SHALL have port s_keep_i, input, T_DATA_RATIO, per-lane valid mask; bit i qualifies s_data_i[i].
REQ-007 SHALL have port s_last_i, input, 1, wide beat ends a packet.
REQ-008 SHALL have port s_valid_i, input, 1, wide beat offered.
REQ-009 SHALL have port s_ready_o, output, 1, wide beat can be accepted.
REQ-010 SHALL have port m_data_o, output, T_DATA_WIDTH, narrow output word.
REQ-011 SHALL have port m_last_o, output, 1, narrow word ends a packet.
REQ-012 SHALL have port m_valid_o, output, 1, narrow word offered.
REQ-013 SHALL have port m_ready_i, input, 1, downstream accepts the narrow word.

Function
REQ-014 SHALL treat a transfer on either side as valid AND ready high at a rising clk edge.
REQ-015 SHALL implement two states:
- IDLE: holding register empty.
- SEND: a wide beat is held in data_q, rem_q (remaining-lane mask) and last_q.
REQ-016 In IDLE, on an input transfer with s_keep_i nonzero, SHALL capture data, keep into rem_q and last, then enter SEND.
REQ-017 On an input transfer with s_keep_i == 0, SHALL consume the beat in one cycle, emit nothing, discard its last flag and stay in IDLE.
REQ-018 In SEND, SHALL drive:
- m_valid_o = 1
- m_data_o = data_q[k], where k is the lowest set bit of rem_q
REQ-019 SHALL emit kept lanes in ascending lane order and skip lanes whose keep bit is 0; emitted words follow input order with no reordering or duplication.
REQ-020 SHALL assert m_last_o only while rem_q has exactly one bit set and last_q == 1; otherwise m_last_o = 0.
REQ-021 On an output transfer, SHALL clear bit k of rem_q; clearing the final bit SHALL return to IDLE unless a new beat is accepted in the same cycle.
REQ-022 SHALL compute s_ready_o combinationally as: state == IDLE OR (rem_q has exactly one bit set AND m_ready_i == 1).
REQ-023 On a same-cycle final output transfer and input transfer with nonzero keep, SHALL load the new beat and remain in SEND, so full-keep beats stream with no bubble.
REQ-024 Latency SHALL be 1 cycle from input transfer to first m_valid_o; throughput SHALL be one narrow word per cycle under no backpressure.
REQ-025 While m_valid_o = 1 and m_ready_i = 0, m_data_o and m_last_o SHALL hold stable and m_valid_o SHALL not drop.
REQ-026 When m_valid_o = 0, m_data_o and m_last_o SHALL be 0.
REQ-027 SHALL not let s_valid_i affect m_valid_o combinationally; there is no input-to-output bypass.

Reset
REQ-028 With rst_n low at a rising edge, SHALL go to IDLE and clear data_q, rem_q and last_q.
REQ-029 During and after reset, SHALL drive m_valid_o = 0, m_last_o = 0, m_data_o = 0 and s_ready_o = 1.
REQ-030 Reset asserted mid-packet SHALL discard the held beat with no further output words.

Verification (T_DATA_WIDTH = 4, T_DATA_RATIO = 2)
REQ-031 Bench SHALL cover: data {lane1 = 4'hB, lane0 = 4'hA}, keep 2'b11, last 1, m_ready_i = 1 -> A with last 0, then B with last 1 on consecutive cycles; s_ready_o is 0 in the A cycle and 1 in the B cycle.
REQ-032 Bench SHALL cover: keep 2'b10, data {4'h7, 4'h3}, last 1 -> exactly one word 4'h7 with m_last_o = 1.
REQ-033 Bench SHALL cover: keep 2'b11, m_ready_i held 0 for 3 cycles -> m_valid_o = 1 and m_data_o = lane0 stable all 3 cycles; s_ready_o = 0 throughout.
REQ-034 Bench SHALL cover: beats {2,1} last 0 then {4,3} last 1, valid continuous, m_ready_i = 1 -> outputs 1,2,3,4 in 4 consecutive cycles; m_last_o only on 4.
REQ-035 Bench SHALL cover: keep 2'b00, last 1 -> beat accepted in 1 cycle; m_valid_o stays 0.
REQ-036 Bench SHALL cover: rst_n pulled low after the first word of a 2-lane beat -> next cycle m_valid_o = 0, s_ready_o = 1; the second lane is never emitted.
